// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and the shared datapath.
//   Datapath -> controller: op, funct3, funct7b5 (from the instruction register) and Flags (from the ALU).
//   Controller -> datapath: register/memory write enables, mux selects, ImmSrc, ALUControl.
//   Controller -> system:   instr_done, illegal.
// The master modport is the controller side. The slave modport is the datapath side.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic [3:0] Flags;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, funct3, funct7b5, Flags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, instr_done, illegal
  );

  modport slave (
    output op, funct3, funct7b5, Flags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I-subset control FSM.
// It sequences a single shared ALU and memory port, and resolves branches from the ALU Flags.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high. It returns the FSM to FETCH and masks all enables.
//   ctrl  : control bus (master side). See multicycle_controller_if for the signal list.
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_controller_if.master       ctrl
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLL   = 4'b0110;
  localparam logic [3:0] ALU_SRL   = 4'b0111;
  localparam logic [3:0] ALU_XOR   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_LUI   = 4'b1011;
  localparam logic [3:0] ALU_AUIPC = 4'b1100;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALR2    = 4'd12,
    S_UPPER    = 4'd13,
    S_ILLEGAL  = 4'd14
  } state_t;

  state_t state_q, state_d;

  logic       zero;
  logic       unused_flags;
  logic       pcw_c, adr_c, memw_c, irw_c, regw_c, done_c, ill_c;
  logic [1:0] rsrc_c, srca_c, srcb_c;
  logic [2:0] imm_c;
  logic [3:0] alu_c;

  assign zero         = ctrl.Flags[2];
  assign unused_flags = ^{ctrl.Flags[3], ctrl.Flags[1:0]};

  // ALU operation for the R-type and I-type execute states.
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7b5, input logic is_r);
    logic [3:0] code;
    case (f3)
      3'b000:  code = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= state_t'(RESET_STATE);
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (ctrl.op)
          OP_LOAD, OP_STORE: state_d = (ctrl.funct3 == 3'b010) ? S_MEMADR : S_ILLEGAL;
          OP_R: state_d = (!ctrl.funct7b5 || ctrl.funct3 == 3'b000 || ctrl.funct3 == 3'b101)
                          ? S_EXECUTER : S_ILLEGAL;
          OP_I:  state_d = S_EXECUTEI;
          OP_BR: state_d = (ctrl.funct3 == 3'b010 || ctrl.funct3 == 3'b011) ? S_ILLEGAL : S_BRANCH;
          OP_JAL:  state_d = S_JAL;
          OP_JALR: state_d = S_JALR;
          OP_LUI, OP_AUIPC: state_d = S_UPPER;
          default: state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (ctrl.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JALR2;
      S_JALR2:    state_d = S_ALUWB;
      S_UPPER:    state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_ILLEGAL;
    endcase
  end

  // Moore outputs from state. PCWrite in BRANCH also depends on Flags.
  always_comb begin
    pcw_c  = 1'b0;
    adr_c  = 1'b0;
    memw_c = 1'b0;
    irw_c  = 1'b0;
    regw_c = 1'b0;
    done_c = 1'b0;
    ill_c  = 1'b0;
    rsrc_c = 2'b00;
    srca_c = 2'b00;
    srcb_c = 2'b00;
    alu_c  = ALU_ADD;
    case (state_q)
      S_FETCH:    begin irw_c = 1'b1; pcw_c = 1'b1; srcb_c = 2'b10; rsrc_c = 2'b10; end
      S_DECODE:   begin srca_c = 2'b01; srcb_c = 2'b01; end
      S_MEMADR:   begin srca_c = 2'b10; srcb_c = 2'b01; end
      S_MEMREAD:  adr_c = 1'b1;
      S_MEMWB:    begin rsrc_c = 2'b01; regw_c = 1'b1; done_c = 1'b1; end
      S_MEMWRITE: begin adr_c = 1'b1; memw_c = 1'b1; done_c = 1'b1; end
      S_EXECUTER: begin srca_c = 2'b10; alu_c = alu_dec(ctrl.funct3, ctrl.funct7b5, 1'b1); end
      S_EXECUTEI: begin
        srca_c = 2'b10;
        srcb_c = 2'b01;
        alu_c  = alu_dec(ctrl.funct3, ctrl.funct7b5, 1'b0);
      end
      S_ALUWB:    begin regw_c = 1'b1; done_c = 1'b1; end
      S_BRANCH: begin
        srca_c = 2'b10;
        done_c = 1'b1;
        case (ctrl.funct3)
          3'b000:  begin alu_c = ALU_SUB;  pcw_c = zero;  end
          3'b001:  begin alu_c = ALU_SUB;  pcw_c = !zero; end
          3'b100:  begin alu_c = ALU_SLT;  pcw_c = !zero; end
          3'b101:  begin alu_c = ALU_SLT;  pcw_c = zero;  end
          3'b110:  begin alu_c = ALU_SLTU; pcw_c = !zero; end
          3'b111:  begin alu_c = ALU_SLTU; pcw_c = zero;  end
          default: pcw_c = 1'b0;
        endcase
      end
      S_JAL, S_JALR2: begin srca_c = 2'b01; srcb_c = 2'b10; pcw_c = 1'b1; end
      S_JALR:     begin srca_c = 2'b10; srcb_c = 2'b01; end
      S_UPPER: begin
        srcb_c = 2'b01;
        if (ctrl.op == OP_AUIPC) begin srca_c = 2'b01; alu_c = ALU_AUIPC; end
        else                     alu_c = ALU_LUI;
      end
      S_ILLEGAL:  ill_c = 1'b1;
      default:    ill_c = 1'b0;
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    imm_c = 3'b000;
    case (ctrl.op)
      OP_STORE:         imm_c = 3'b001;
      OP_BR:            imm_c = 3'b010;
      OP_JAL:           imm_c = 3'b011;
      OP_LUI, OP_AUIPC: imm_c = 3'b100;
      default:          imm_c = 3'b000;
    endcase
  end

  // Enables are masked while reset is high so that an abort never leaves a partial write.
  assign ctrl.PCWrite    = pcw_c  & ~reset;
  assign ctrl.MemWrite   = memw_c & ~reset;
  assign ctrl.IRWrite    = irw_c  & ~reset;
  assign ctrl.RegWrite   = regw_c & ~reset;
  assign ctrl.instr_done = done_c & ~reset;
  assign ctrl.illegal    = ill_c  & ~reset;
  assign ctrl.AdrSrc     = adr_c;
  assign ctrl.ResultSrc  = rsrc_c;
  assign ctrl.ALUSrcA    = srca_c;
  assign ctrl.ALUSrcB    = srcb_c;
  assign ctrl.ImmSrc     = imm_c;
  assign ctrl.ALUControl = alu_c;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller.
// Each cycle's expected control vector is queued when an instruction is applied.
// Vectors are popped and compared as the DUT steps through that instruction.
module tb_multicycle_controller;

  typedef enum int {K_R, K_I, K_BR, K_LD, K_ST, K_JAL, K_JALR, K_LUI, K_AUIPC, K_ILL} kind_e;

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, ORR = 4'b0011, SLT = 4'b0101,
                         SRL = 4'b0111, XOR = 4'b1000, SLTU = 4'b1001, SRA = 4'b1010,
                         LUI = 4'b1011, AUIPC = 4'b1100;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [19:0] exp_q[$];

  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Vector layout: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc ALUSrcA ALUSrcB ImmSrc ALUControl instr_done illegal
  function automatic logic [19:0] vec(input logic pcw, input logic adr, input logic mw, input logic irw,
                                      input logic rw, input logic [1:0] rs, input logic [1:0] a,
                                      input logic [1:0] b, input logic [2:0] im, input logic [3:0] alu,
                                      input logic done, input logic ill);
    return {pcw, adr, mw, irw, rw, rs, a, b, im, alu, done, ill};
  endfunction

  function automatic logic [19:0] sample();
    return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ResultSrc,
            bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl, bus.instr_done, bus.illegal};
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      7'b0100011:             return 3'b001;
      7'b1100011:             return 3'b010;
      7'b1101111:             return 3'b011;
      7'b0110111, 7'b0010111: return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] reset_vec();
    return vec(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm_of(bus.op), ADD, 0, 0);
  endfunction

  // Queue the per-cycle expectations for one instruction.
  task automatic push_instr(input logic [6:0] op, input kind_e k, input logic [3:0] alu,
                            input logic pcw, input int ill_cycles);
    logic [2:0] im;
    logic [19:0] wb;
    im = imm_of(op);
    wb = vec(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, ADD, 1, 0);
    exp_q.push_back(vec(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, im, ADD, 0, 0));
    exp_q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, ADD, 0, 0));
    case (k)
      K_R:  begin exp_q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, alu, 0, 0)); exp_q.push_back(wb); end
      K_I:  begin exp_q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, alu, 0, 0)); exp_q.push_back(wb); end
      K_BR: exp_q.push_back(vec(pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, alu, 1, 0));
      K_LD: begin
        exp_q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, ADD, 0, 0));
        exp_q.push_back(vec(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, ADD, 0, 0));
        exp_q.push_back(vec(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, im, ADD, 1, 0));
      end
      K_ST: begin
        exp_q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, ADD, 0, 0));
        exp_q.push_back(vec(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, im, ADD, 1, 0));
      end
      K_JAL: begin exp_q.push_back(vec(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, im, ADD, 0, 0)); exp_q.push_back(wb); end
      K_JALR: begin
        exp_q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, ADD, 0, 0));
        exp_q.push_back(vec(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, im, ADD, 0, 0));
        exp_q.push_back(wb);
      end
      K_LUI:   begin exp_q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, im, LUI, 0, 0)); exp_q.push_back(wb); end
      K_AUIPC: begin exp_q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, AUIPC, 0, 0)); exp_q.push_back(wb); end
      default: for (int i = 0; i < ill_cycles; i++)
                 exp_q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, ADD, 0, 1));
    endcase
  endtask

  // Called on a falling edge with the FSM in FETCH. It returns on the falling edge after the last queued cycle.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [3:0] fl, input kind_e k, input logic [3:0] alu, input logic pcw,
                           input int ill_cycles);
    int n;
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.Flags = fl;
    push_instr(op, k, alu, pcw, ill_cycles);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      #1;
      check_eq($sformatf("%s cyc%0d", name, i + 1), 32'(sample()), 32'(exp_q.pop_front()));
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    #1;
    check_eq({name, " in reset"}, 32'(sample()), 32'(reset_vec()));
    @(negedge clk);
    #1;
    check_eq({name, " held reset"}, 32'(sample()), 32'(reset_vec()));
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0; bus.Flags = 4'd0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset state", 32'(sample()), 32'(reset_vec()));
    @(negedge clk);
    reset = 1'b0;

    run_instr("add",   7'b0110011, 3'b000, 1'b0, 4'b0000, K_R, ADD,  1'b0, 0);
    run_instr("sub",   7'b0110011, 3'b000, 1'b1, 4'b0000, K_R, SUB,  1'b0, 0);
    run_instr("sra",   7'b0110011, 3'b101, 1'b1, 4'b0000, K_R, SRA,  1'b0, 0);
    run_instr("srl",   7'b0110011, 3'b101, 1'b0, 4'b0000, K_R, SRL,  1'b0, 0);
    run_instr("or",    7'b0110011, 3'b110, 1'b0, 4'b0000, K_R, ORR,  1'b0, 0);
    run_instr("sltu",  7'b0110011, 3'b011, 1'b0, 4'b0000, K_R, SLTU, 1'b0, 0);
    run_instr("srai",  7'b0010011, 3'b101, 1'b1, 4'b0000, K_I, SRA,  1'b0, 0);
    run_instr("addi7", 7'b0010011, 3'b000, 1'b1, 4'b0000, K_I, ADD,  1'b0, 0);
    run_instr("xori",  7'b0010011, 3'b100, 1'b0, 4'b0000, K_I, XOR,  1'b0, 0);
    run_instr("beq_t", 7'b1100011, 3'b000, 1'b0, 4'b0100, K_BR, SUB, 1'b1, 0);
    run_instr("beq_n", 7'b1100011, 3'b000, 1'b0, 4'b0000, K_BR, SUB, 1'b0, 0);
    run_instr("bne_n", 7'b1100011, 3'b001, 1'b0, 4'b0100, K_BR, SUB, 1'b0, 0);
    run_instr("blt_t", 7'b1100011, 3'b100, 1'b0, 4'b1000, K_BR, SLT, 1'b1, 0);
    run_instr("bge_n", 7'b1100011, 3'b101, 1'b0, 4'b0000, K_BR, SLT, 1'b0, 0);
    run_instr("bgeu",  7'b1100011, 3'b111, 1'b0, 4'b0100, K_BR, SLTU, 1'b1, 0);
    run_instr("lw",    7'b0000011, 3'b010, 1'b0, 4'b0000, K_LD, ADD, 1'b0, 0);
    run_instr("sw",    7'b0100011, 3'b010, 1'b0, 4'b0000, K_ST, ADD, 1'b0, 0);
    run_instr("jal",   7'b1101111, 3'b000, 1'b0, 4'b0000, K_JAL, ADD, 1'b0, 0);
    run_instr("jalr",  7'b1100111, 3'b000, 1'b0, 4'b0000, K_JALR, ADD, 1'b0, 0);
    run_instr("lui",   7'b0110111, 3'b000, 1'b0, 4'b0000, K_LUI, LUI, 1'b0, 0);
    run_instr("auipc", 7'b0010111, 3'b000, 1'b0, 4'b0000, K_AUIPC, AUIPC, 1'b0, 0);

    run_instr("bad_op", 7'b1111111, 3'b000, 1'b0, 4'b0000, K_ILL, ADD, 1'b0, 10);
    do_reset("bad_op");
    run_instr("lb",     7'b0000011, 3'b000, 1'b0, 4'b0000, K_ILL, ADD, 1'b0, 10);
    do_reset("lb");
    run_instr("sll_f7", 7'b0110011, 3'b001, 1'b1, 4'b0000, K_ILL, ADD, 1'b0, 3);
    do_reset("sll_f7");
    run_instr("br_f3",  7'b1100011, 3'b011, 1'b0, 4'b0100, K_ILL, ADD, 1'b0, 3);
    do_reset("br_f3");
    run_instr("add2",   7'b0110011, 3'b000, 1'b0, 4'b0000, K_R, ADD, 1'b0, 0);

    // Store aborted by an asynchronous reset in the middle of its MEMWRITE cycle.
    bus.op = 7'b0100011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.Flags = 4'b0000;
    push_instr(7'b0100011, K_ST, ADD, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("sw_abort cyc%0d", i + 1), 32'(sample()), 32'(exp_q.pop_front()));
      if (i < 3) @(negedge clk);
    end
    #2;
    reset = 1'b1;
    #1;
    check_eq("sw_abort MemWrite", 32'(bus.MemWrite), 32'd0);
    check_eq("sw_abort vec", 32'(sample()), 32'(reset_vec()));
    @(negedge clk);
    reset = 1'b0;
    run_instr("after_abort", 7'b0110011, 3'b111, 1'b0, 4'b0000, K_R, 4'b0010, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multicycle RISC-V (RV32I subset) control FSM. It produces the ALU's 4-bit ALUControl code and the datapath select/enable signals, and consumes the ALU's Flags to resolve branches. It sits between the instruction register and the shared datapath: a single ALU and a single memory port, reused across cycles.

Parameters:
- RESET_STATE, 4'd0 (FETCH), state entered on reset.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- op  input  7  instr[6:0]
- funct3  input  3  instr[14:12]
- funct7b5  input  1  instr[30]
- Flags  input  4  ALU flags {Negative, Zero, Carry, Overflow}; Zero=1 iff Result==0
- PCWrite  output  1  PC load enable
- AdrSrc  output  1  mem address: 0=PC, 1=Result
- MemWrite  output  1  memory write enable
- IRWrite  output  1  instruction/OldPC register load
- RegWrite  output  1  register file write enable
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=RD1
- ALUSrcB  output  2  00=RD2, 01=ImmExt, 10=const 4
- ImmSrc  output  3  000=I, 001=S, 010=B, 011=J, 100=U (raw instr[31:12]; ALU applies <<12)
- ALUControl  output  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0101 SLT, 0110 SLL, 0111 SRL, 1000 XOR, 1001 SLTU, 1010 SRA, 1011 LUI, 1100 AUIPC
- instr_done  output  1  one-cycle pulse in the final cycle of each instruction
- illegal  output  1  sticky; set in ILLEGAL state

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. While reset=1, state=FETCH, and PCWrite, MemWrite, IRWrite, RegWrite, instr_done and illegal are all forced 0.
- Reset mid-instruction: aborts immediately. No partial write enables are asserted.
- Output style: Moore outputs from state, except PCWrite in BRANCH, which is combinational on Flags and funct3.
- Defaults in every state: all enables 0, selects 00, ALUControl=ADD.
- ImmSrc: combinational on op in all states. Loads/JALR/OP-IMM=I, store=S, branch=B, JAL=J, LUI/AUIPC=U.
- FETCH: AdrSrc=0, IRWrite=1, A=PC, B=4, ADD, ResultSrc=10, PCWrite=1 -> DECODE.
- DECODE: A=OldPC, B=Imm, ADD (target latched into ALUOut). Next state by op:
  - 0000011 (funct3=010) -> MEMADR
  - 0100011 (funct3=010) -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 (funct3 not 010/011) -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111/0010111 -> UPPER
  - anything else, or a listed funct3/funct7 violation -> ILLEGAL
- R-type with funct7b5=1 is legal only for funct3 000/101.
- MEMADR: A=RD1, B=Imm, ADD. Next MEMREAD (load) or MEMWRITE (store).
- MEMREAD: AdrSrc=1, ResultSrc=00 -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, done -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, done -> FETCH.
- EXECUTER: A=RD1, B=RD2, decoded op -> ALUWB. EXECUTEI is the same with B=Imm.
- ALU decode by funct3:
  - 000: ADD, or SUB only when R-type with funct7b5=1
  - 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 110 OR; 111 AND
  - 101: SRL, or SRA when funct7b5=1 (R and I)
- ALUWB: ResultSrc=00, RegWrite=1, done -> FETCH.
- BRANCH: A=RD1, B=RD2, ResultSrc=00. Compare op and PCWrite condition:
  - BEQ: SUB, PCWrite=Zero
  - BNE: SUB, PCWrite=~Zero
  - BLT: SLT, PCWrite=~Zero
  - BGE: SLT, PCWrite=Zero
  - BLTU: SLTU, PCWrite=~Zero
  - BGEU: SLTU, PCWrite=Zero
  - Then done -> FETCH.
- JAL: A=OldPC, B=4, ADD, ResultSrc=00, PCWrite=1 -> ALUWB.
- JALR: A=RD1, B=Imm, ADD -> JALR2.
- JALR2: A=OldPC, B=4, ADD, ResultSrc=00, PCWrite=1 -> ALUWB.
- UPPER: B=Imm. LUI: ALUControl=1011. AUIPC: A=OldPC, ALUControl=1100. -> ALUWB.
- ILLEGAL: all enables 0, illegal=1, self-loop. Exits only via reset.
- Latency (cycles incl. FETCH): load 5, store 4, R/I 4, branch 3, JAL 4, JALR 5, LUI/AUIPC 4.
- instr_done: exactly one pulse per retired instruction. Never asserted in ILLEGAL.

Test Plan:
- add x3,x1,x2 (op=0110011, f3=000, f7b5=0) -> state sequence FETCH, DECODE, EXECUTER, ALUWB. ALUControl=0000 in EXECUTER, RegWrite=1 in cycle 4, instr_done=1 in cycle 4 only.
- sub and sra (f7b5=1; f3=000 / 101) -> ALUControl 0001 / 1010. srai (op=0010011, f3=101, f7b5=1) -> 1010. addi with f7b5=1 -> 0000.
- beq with Flags=4'b0100 -> PCWrite=1, ResultSrc=00 in cycle 3. Same with Flags=4'b0000 -> PCWrite=0. bgeu with Flags Zero=1 -> PCWrite=1, ALUControl=1001.
- lw then sw (f3=010) -> lw asserts RegWrite/ResultSrc=01 in cycle 5. sw asserts MemWrite=1, AdrSrc=1 in cycle 4 and never RegWrite.
- op=7'b1111111, or lb (f3=000) -> ILLEGAL after DECODE. illegal=1 stays set, no enables for 10 cycles, then reset -> FETCH with illegal=0.
- Assert reset asynchronously in MEMWRITE (mid-cycle) -> MemWrite drops immediately. State=FETCH. After release, IRWrite=1 on the first cycle.
